// File: rtl/bsg_dram_req_pkg.sv
// Shared types for the DRAM channel request issue stage: command layout and
// protocol-error causes.
`ifndef BSG_DRAM_REQ_PKG_SV
`define BSG_DRAM_REQ_PKG_SV

// Command FIFO entry; address width is fixed by the instantiating module.
`define BSG_DRAM_REQ_CMD_S(addr_w) struct packed { logic write_not_read; logic [(addr_w)-1:0] addr; }

package bsg_dram_req_pkg;

  typedef enum logic [1:0] {
    e_err_none,
    e_err_cmd_underflow,
    e_err_data_underflow,
    e_err_credit_underflow
  } err_cause_e;

  // Pointer width with one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int els);
    return $clog2(els) + 1;
  endfunction

endpackage

`endif

// File: rtl/bsg_dram_req_fifo.sv
// In-order 1r1w FIFO: valid/ready push, yumi pop, wrap-bit pointers,
// asynchronous active-high reset. No bypass: a push is visible one cycle later.
module bsg_dram_req_fifo
  import bsg_dram_req_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w = ptr_width(els_p);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   wr_ptr_r, rd_ptr_r;
  logic               live_r;
  logic               full, empty, push, pop;

  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign full    = (wr_ptr_r == {~rd_ptr_r[ptr_w-1], rd_ptr_r[ptr_w-2:0]});
  // Ready is held low until the first edge after reset release; full blocks push even if popping.
  assign ready_o = live_r & ~full;
  assign v_o     = ~empty;
  assign data_o  = mem[rd_ptr_r[ptr_w-2:0]];
  assign push    = v_i & ready_o;
  assign pop     = yumi_i & ~empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      live_r   <= 1'b0;
    end else begin
      live_r <= 1'b1;
      if (push) wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + ptr_w'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_r[ptr_w-2:0]] <= data_i;
  end

endmodule

// File: rtl/bsg_dram_ch_req_issue.sv
// Per-channel DRAM request issue: pairs buffered commands with write data,
// throttles reads against a return-credit limit, and flags protocol errors.
// Handshakes: push when v & ready (ready never depends on v); pop when yumi,
// which the consumer may raise only while the matching valid is high.
module bsg_dram_ch_req_issue
  import bsg_dram_req_pkg::*;
#(
  parameter int channel_addr_width_p = 16,
  parameter int data_width_p         = 32,
  parameter int cmd_els_p            = 4,
  parameter int data_els_p           = 4,
  parameter int max_reads_p          = 8,
  localparam int credit_w            = $clog2(max_reads_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            cmd_v_i,
  input  logic                            cmd_write_not_read_i,
  input  logic [channel_addr_width_p-1:0] cmd_addr_i,
  output logic                            cmd_ready_o,
  input  logic                            wdata_v_i,
  input  logic [data_width_p-1:0]         wdata_i,
  output logic                            wdata_ready_o,
  output logic                            v_o,
  output logic                            write_not_read_o,
  output logic [channel_addr_width_p-1:0] ch_addr_o,
  input  logic                            yumi_i,
  output logic                            data_v_o,
  output logic [data_width_p-1:0]         data_o,
  input  logic                            data_yumi_i,
  input  logic                            rdata_v_i,
  output logic [credit_w-1:0]             reads_outstanding_o,
  output logic                            idle_o,
  output logic                            err_o
);

  typedef `BSG_DRAM_REQ_CMD_S(channel_addr_width_p) cmd_s;

  cmd_s                cmd_in, cmd_head;
  logic                cmd_head_v, cmd_pop, data_pop;
  logic                read_issue, credit_ret, credit_ok;
  logic [credit_w-1:0] credits_r, credits_n;
  logic                err_r;
  err_cause_e          err_cause;

  assign cmd_in.write_not_read = cmd_write_not_read_i;
  assign cmd_in.addr           = cmd_addr_i;

  bsg_dram_req_fifo #(.width_p($bits(cmd_s)), .els_p(cmd_els_p)) cmd_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (cmd_v_i),
    .data_i  (cmd_in),
    .ready_o (cmd_ready_o),
    .v_o     (cmd_head_v),
    .data_o  (cmd_head),
    .yumi_i  (cmd_pop)
  );

  bsg_dram_req_fifo #(.width_p(data_width_p), .els_p(data_els_p)) data_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (wdata_v_i),
    .data_i  (wdata_i),
    .ready_o (wdata_ready_o),
    .v_o     (data_v_o),
    .data_o  (data_o),
    .yumi_i  (data_pop)
  );

  // A credit-starved read at the head blocks everything behind it.
  assign credit_ok        = (credits_r < credit_w'(max_reads_p));
  assign v_o              = cmd_head_v & (cmd_head.write_not_read ? data_v_o : credit_ok);
  assign write_not_read_o = cmd_head.write_not_read;
  assign ch_addr_o        = cmd_head.addr;

  always_comb begin
    cmd_pop    = yumi_i & v_o;
    data_pop   = data_yumi_i & data_v_o;
    read_issue = cmd_pop & ~cmd_head.write_not_read;
    // A return in the same cycle as a read issue is legal even from zero.
    credit_ret = rdata_v_i & ((credits_r != '0) | read_issue);

    err_cause = e_err_none;
    if (yumi_i & ~v_o)                 err_cause = e_err_cmd_underflow;
    else if (data_yumi_i & ~data_v_o)  err_cause = e_err_data_underflow;
    else if (rdata_v_i & ~credit_ret)  err_cause = e_err_credit_underflow;

    credits_n = credits_r;
    case ({read_issue, credit_ret})
      2'b10:   credits_n = credits_r + credit_w'(1);
      2'b01:   credits_n = credits_r - credit_w'(1);
      default: credits_n = credits_r;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      credits_r <= '0;
      err_r     <= 1'b0;
    end else begin
      credits_r <= credits_n;
      if (err_cause != e_err_none) err_r <= 1'b1;
    end
  end

  assign reads_outstanding_o = credits_r;
  assign err_o               = err_r;
  assign idle_o              = ~cmd_head_v & ~data_v_o & (credits_r == '0);

endmodule

// File: doc/bsg_dram_ch_req_issue.md
# bsg_dram_ch_req_issue

Per-channel request issue stage that sits directly upstream of the DRAMSim3 channel model in the test DRAM subsystem. It buffers independent command and write-data streams from a client and presents them to one DRAM channel port with correct write/data pairing. It throttles reads against a credit limit so the client's read-return buffer cannot overflow, and it reports occupancy, idle and protocol-error status.

## Interface
- channel_addr_width_p, none: channel-local address width.
- data_width_p, none: write/read data width.
- cmd_els_p, 4: command FIFO depth (power of 2, ≥2).
- data_els_p, 4: write-data FIFO depth (power of 2, ≥2).
- max_reads_p, 8: maximum outstanding reads (≥1).
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- cmd_v_i  in  1  client command valid.
- cmd_write_not_read_i  in  1  command type.
- cmd_addr_i  in  channel_addr_width_p  command address.
- cmd_ready_o  out  1  command FIFO not full.
- wdata_v_i  in  1  client write data valid.
- wdata_i  in  data_width_p  write data.
- wdata_ready_o  out  1  data FIFO not full.
- v_o  out  1  DRAM request valid.
- write_not_read_o  out  1  DRAM request type.
- ch_addr_o  out  channel_addr_width_p  DRAM request address.
- yumi_i  in  1  DRAM accepted request.
- data_v_o  out  1  write data valid toward DRAM.
- data_o  out  data_width_p  write data toward DRAM.
- data_yumi_i  in  1  DRAM consumed write data.
- rdata_v_i  in  1  read data returned by DRAM; returns one credit.
- reads_outstanding_o  out  clog2(max_reads_p+1)  current outstanding reads.
- idle_o  out  1  both FIFOs empty and reads_outstanding_o==0.
- err_o  out  1  sticky protocol error.

## Operation
- Command FIFO entries hold {write_not_read, addr}. Data FIFO holds write beats. Both FIFOs are strictly in order.
- Enqueue conditions:
  - Command: cmd_v_i & cmd_ready_o.
  - Data: wdata_v_i & wdata_ready_o.
- v_o = cmd head valid & (head is write ? data FIFO non-empty : reads_outstanding_o < max_reads_p).
- write_not_read_o and ch_addr_o always show the command FIFO head. They hold stable while v_o=1 and yumi_i=0.
- data_v_o = data FIFO non-empty. data_o = data FIFO head.
- Pops:
  - yumi_i pops the command FIFO.
  - data_yumi_i pops the data FIFO.
  - The two pops are independent.
- Head-of-line blocking: a read starved of credits blocks any following writes.
- Credit counter:
  - +1 on yumi_i with a read head.
  - −1 on rdata_v_i.
  - Both in the same cycle: unchanged.
- err_o sets and holds until reset on any of:
  - yumi_i while v_o=0.
  - data_yumi_i while data_v_o=0.
  - rdata_v_i while the counter is 0 and no read is being issued that cycle.
- On error, the offending pop or decrement is suppressed.

## Timing
- While reset_i is asserted: all FIFOs empty, counter 0, err_o=0, cmd_ready_o=wdata_ready_o=0, v_o=data_v_o=0, idle_o=1. Ready outputs rise in the first cycle after reset deassertion.
- Reset asserted mid-operation discards all buffered commands, data and credits immediately (asynchronously).
- Enqueue-to-output latency is 1 cycle: a command accepted at edge N can appear on v_o after edge N, with no bypass.
- Full FIFO: simultaneous push and pop is not allowed. cmd_ready_o is 0 when full, regardless of pop.
- Empty FIFO: a push becomes visible the next cycle.
- reads_outstanding_o and idle_o are registered-state derived, with no combinational path from yumi_i or rdata_v_i.
- Pointers wrap modulo depth. An extra wrap bit distinguishes full from empty.
- At max_reads_p the counter saturates, and v_o stays low for read heads until a credit returns.

## Structure
- Package bsg_dram_req_pkg: cmd struct {write_not_read, addr} parameterized via a width macro, and an error-cause enum for assertions.
- Sub-module bsg_dram_req_fifo: 1r1w FIFO with asynchronous active-high reset, parameterized width/depth, valid/ready push and yumi pop. Instantiated twice (command, data).
- Credit counter, v_o gating and error logic live in the top module.

## Test plan
- Read credit limit:
  - Stimulus: max_reads_p=2; 3 reads to addr 0x10/0x20/0x30; yumi_i always 1; no rdata.
  - Required: two issued; v_o=0 with head 0x30; reads_outstanding_o=2. One rdata_v_i pulse → 0x30 issued next cycle.
- Write waits for data:
  - Stimulus: write command to 0x40; data 0xDEAD arrives 3 cycles later.
  - Required: v_o stays 0 until the cycle after data enqueue, then v_o=1 with data_o=0xDEAD.
- Backpressure and FIFO full:
  - Stimulus: cmd_els_p=4; yumi_i=0; push 5 commands.
  - Required: cmd_ready_o=0 after 4. Outputs stay stable on entry 0. Releasing yumi_i drains entries in order with wrap.
- Simultaneous issue and return:
  - Stimulus: counter=1; read yumi_i and rdata_v_i in the same cycle.
  - Required: counter stays 1; err_o stays 0.
- Error detection:
  - Stimulus: rdata_v_i with counter 0.
  - Required: err_o=1 next cycle and sticky; counter stays 0.
- Asynchronous reset mid-traffic:
  - Stimulus: 3 commands queued, 2 reads outstanding; assert reset_i between clock edges.
  - Required: v_o=0, reads_outstanding_o=0, idle_o=1 immediately, without waiting for a clock edge.
